// File: rtl/tx_ll_frame_arbiter.sv
// Frame-granular round-robin arbiter for up to four local-link sources feeding one TX FIFO port.
// A grant is held until the frame's EOF beat. Frames that begin without SOF are swallowed and flagged.
module tx_ll_frame_arbiter #(
  parameter int N_SRC = 4
) (
  input  logic               tx_ll_clock,
  input  logic               tx_ll_reset,
  input  logic [8*N_SRC-1:0] src_data,
  input  logic [N_SRC-1:0]   src_sof_n,
  input  logic [N_SRC-1:0]   src_eof_n,
  input  logic [N_SRC-1:0]   src_src_rdy_n,
  output logic [N_SRC-1:0]   src_dst_rdy_n,
  output logic [7:0]         tx_ll_data_out,
  output logic               tx_ll_sof_out_n,
  output logic               tx_ll_eof_out_n,
  output logic               tx_ll_src_rdy_out_n,
  input  logic               tx_ll_dst_rdy_in_n,
  output logic [1:0]         grant_id,
  output logic               busy,
  output logic [15:0]        frame_count,
  output logic [N_SRC-1:0]   sof_error,
  input  logic               clr_stats
);

  typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;

  state_t             state_reg;
  logic [1:0]         grant_reg;
  logic [1:0]         last_grant_reg;
  logic               first_beat_reg;
  logic [15:0]        frame_count_reg;
  logic [N_SRC-1:0]   sof_error_reg;

  logic [7:0]         src_data_arr [N_SRC];
  logic [7:0]         g_data;
  logic               g_sof_n;
  logic               g_eof_n;
  logic               g_src_rdy_n;
  logic               bad_sof;
  logic               pass;
  logic               consume;
  logic               gnt_dst_rdy_n;
  logic               fwd_xfer;
  logic               eat_beat;
  logic               frame_done;
  logic               win_found;
  logic [1:0]         win_idx;
  logic [1:0]         cand;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign src_data_arr[gi]  = src_data[8*gi +: 8];
    assign src_dst_rdy_n[gi] = (state_reg != IDLE && grant_reg == 2'(gi)) ? gnt_dst_rdy_n : 1'b1;
  end

  assign g_data      = src_data_arr[grant_reg];
  assign g_sof_n     = src_sof_n[grant_reg];
  assign g_eof_n     = src_eof_n[grant_reg];
  assign g_src_rdy_n = src_src_rdy_n[grant_reg];

  // A first beat lacking SOF is consumed but never reaches the FIFO.
  assign bad_sof    = (state_reg == XFER) && first_beat_reg && g_sof_n;
  assign pass       = (state_reg == XFER) && !bad_sof;
  assign consume    = bad_sof || (state_reg == DROP);
  assign fwd_xfer   = pass && !g_src_rdy_n && !tx_ll_dst_rdy_in_n;
  assign eat_beat   = consume && !g_src_rdy_n;
  assign frame_done = fwd_xfer && !g_eof_n;

  always_comb begin
    tx_ll_data_out      = 8'h00;
    tx_ll_sof_out_n     = 1'b1;
    tx_ll_eof_out_n     = 1'b1;
    tx_ll_src_rdy_out_n = 1'b1;
    gnt_dst_rdy_n       = 1'b1;
    if (pass) begin
      tx_ll_data_out      = g_data;
      tx_ll_sof_out_n     = g_sof_n;
      tx_ll_eof_out_n     = g_eof_n;
      tx_ll_src_rdy_out_n = g_src_rdy_n;
      gnt_dst_rdy_n       = tx_ll_dst_rdy_in_n;
    end else if (consume) begin
      gnt_dst_rdy_n = 1'b0;
    end
  end

  // Round-robin search starting just above the most recent grant.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N_SRC; k++) begin
      cand = 2'((int'(last_grant_reg) + k) % N_SRC);
      if (!win_found && !src_src_rdy_n[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge tx_ll_clock) begin
    if (tx_ll_reset) begin
      state_reg       <= IDLE;
      grant_reg       <= '0;
      last_grant_reg  <= 2'(N_SRC - 1);
      first_beat_reg  <= 1'b0;
      frame_count_reg <= '0;
      sof_error_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            grant_reg      <= win_idx;
            last_grant_reg <= win_idx;
            first_beat_reg <= 1'b1;
            state_reg      <= XFER;
          end
        end
        XFER: begin
          if (bad_sof) begin
            if (eat_beat) begin
              first_beat_reg <= 1'b0;
              state_reg      <= g_eof_n ? DROP : IDLE;
            end
          end else if (fwd_xfer) begin
            first_beat_reg <= 1'b0;
            if (!g_eof_n) state_reg <= IDLE;
          end
        end
        DROP: begin
          if (eat_beat && !g_eof_n) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      // Clearing wins over a same-cycle increment or sticky set.
      if (clr_stats) begin
        frame_count_reg <= '0;
        sof_error_reg   <= '0;
      end else begin
        if (frame_done) frame_count_reg <= frame_count_reg + 16'd1;
        if (bad_sof && eat_beat) sof_error_reg[grant_reg] <= 1'b1;
      end
    end
  end

  assign grant_id    = grant_reg;
  assign busy        = (state_reg != IDLE);
  assign frame_count = frame_count_reg;
  assign sof_error   = sof_error_reg;

endmodule

// File: tb/tb_tx_ll_frame_arbiter.sv
// Directed bench for tx_ll_frame_arbiter: arbitration, rotation, back-pressure, SOF errors, stats clear, reset.
module tb_tx_ll_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_data;
  logic [3:0]  sof_n, eof_n, rdy_n;
  logic [3:0]  dst_rdy_n;
  logic [7:0]  dout;
  logic        sof_o, eof_o, rdy_o;
  logic        dst_in_n;
  logic [1:0]  gid;
  logic        busy;
  logic [15:0] fc;
  logic [3:0]  serr;
  logic        clr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tx_ll_frame_arbiter #(.N_SRC(4)) dut (
    .tx_ll_clock         (clk),
    .tx_ll_reset         (rst),
    .src_data            (src_data),
    .src_sof_n           (sof_n),
    .src_eof_n           (eof_n),
    .src_src_rdy_n       (rdy_n),
    .src_dst_rdy_n       (dst_rdy_n),
    .tx_ll_data_out      (dout),
    .tx_ll_sof_out_n     (sof_o),
    .tx_ll_eof_out_n     (eof_o),
    .tx_ll_src_rdy_out_n (rdy_o),
    .tx_ll_dst_rdy_in_n  (dst_in_n),
    .grant_id            (gid),
    .busy                (busy),
    .frame_count         (fc),
    .sof_error           (serr),
    .clr_stats           (clr)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_src();
    src_data = '0;
    sof_n    = 4'hF;
    eof_n    = 4'hF;
    rdy_n    = 4'hF;
  endtask

  task automatic set_beat(input int s, input logic [7:0] d, input logic sof, input logic eof);
    src_data[8*s +: 8] = d;
    sof_n[s] = sof;
    eof_n[s] = eof;
    rdy_n[s] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; dst_in_n = 1'b0;
    idle_src();
    cyc(); cyc();
    @(negedge clk);
    n_checks++; if (dst_rdy_n !== 4'hF) begin n_fail++; $display("FAIL rst_dst_rdy: got %h want f", dst_rdy_n); end
    n_checks++; if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL rst_src_rdy_out: got %b want 1", rdy_o); end
    n_checks++; if ({sof_o, eof_o} !== 2'b11) begin n_fail++; $display("FAIL rst_sof_eof: got %b want 11", {sof_o, eof_o}); end
    n_checks++; if (dout !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", dout); end
    n_checks++; if (gid !== 2'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_grant_busy: got %0d/%b want 0/0", gid, busy); end
    n_checks++; if (fc !== 16'd0 || serr !== 4'h0) begin n_fail++; $display("FAIL rst_stats: got %0d/%b want 0/0000", fc, serr); end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset done");
  endtask

  task automatic test_single_frame();
    logic [7:0] exp_d;
    set_beat(2, 8'h20, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++; if (dst_rdy_n !== 4'hF || busy !== 1'b0) begin n_fail++; $display("FAIL sf_idle: got %h/%b want f/0", dst_rdy_n, busy); end
    cyc();
    for (int b = 0; b < 5; b++) begin
      exp_d = 8'h20 + 8'(b);
      set_beat(2, exp_d, b != 0, b != 4);
      @(negedge clk);
      n_checks++; if (gid !== 2'd2) begin n_fail++; $display("FAIL sf_grant beat %0d: got %0d want 2", b, gid); end
      n_checks++; if (dst_rdy_n !== 4'b1011 || rdy_o !== 1'b0) begin n_fail++; $display("FAIL sf_handshake beat %0d: got %b/%b want 1011/0", b, dst_rdy_n, rdy_o); end
      n_checks++; if (dout !== exp_d) begin n_fail++; $display("FAIL sf_data beat %0d: got %h want %h", b, dout, exp_d); end
      n_checks++; if (sof_o !== (b != 0) || eof_o !== (b != 4)) begin n_fail++; $display("FAIL sf_flags beat %0d: got sof %b eof %b", b, sof_o, eof_o); end
      cyc();
    end
    idle_src();
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || fc !== 16'd1) begin n_fail++; $display("FAIL sf_done: got busy %b count %0d want 0/1", busy, fc); end
    $display("single frame from src 2, frame_count=%0d", fc);
    cyc();
  endtask

  task automatic test_round_robin();
    int bc[4];
    int frames = 0, idle_run = 0, cycles = 0;
    logic prev_busy = 1'b0;
    logic [7:0] exp_d;
    rst = 1'b1; idle_src(); cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) bc[i] = 0;
    while (frames < 8 && cycles < 200) begin
      for (int i = 0; i < 4; i++) set_beat(i, 8'(8'h40 + 16*i + bc[i]), bc[i] != 0, bc[i] != 2);
      @(negedge clk);
      if (busy && !prev_busy) begin
        n_checks++; if (gid !== 2'(frames % 4)) begin n_fail++; $display("FAIL rr_order frame %0d: got %0d want %0d", frames, gid, frames % 4); end
        n_checks++; if (idle_run != 1) begin n_fail++; $display("FAIL rr_gap frame %0d: got %0d idle cycles want 1", frames, idle_run); end
        idle_run = 0;
      end
      if (!busy) idle_run++;
      if (!rdy_o && !dst_in_n) begin
        exp_d = 8'(8'h40 + 16*gid + bc[gid]);
        n_checks++; if (dout !== exp_d) begin n_fail++; $display("FAIL rr_data: got %h want %h", dout, exp_d); end
        if (!eof_o) begin
          frames++;
          $display("rr frame %0d from src %0d", frames, gid);
        end
      end
      for (int i = 0; i < 4; i++) if (!dst_rdy_n[i] && !rdy_n[i]) bc[i] = (bc[i] + 1) % 3;
      prev_busy = busy;
      cycles++;
      cyc();
    end
    idle_src();
    n_checks++; if (frames != 8) begin n_fail++; $display("FAIL rr_timeout: got %0d frames want 8", frames); end
    @(negedge clk);
    n_checks++; if (fc !== 16'd8 || busy !== 1'b0) begin n_fail++; $display("FAIL rr_count: got %0d/%b want 8/0", fc, busy); end
    cyc();
  endtask

  task automatic test_backpressure();
    int k = 0, cycles = 0;
    logic [7:0] exp_d;
    while (k < 8 && cycles < 60) begin
      set_beat(0, 8'(8'h10 + k), k != 0, k != 7);
      set_beat(1, 8'hAA, 1'b0, 1'b0);
      dst_in_n = (cycles % 2 == 0);
      @(negedge clk);
      if (busy) begin
        n_checks++; if (gid !== 2'd0) begin n_fail++; $display("FAIL bp_grant: got %0d want 0", gid); end
        n_checks++; if (dst_rdy_n !== {3'b111, dst_in_n}) begin n_fail++; $display("FAIL bp_stall: got %b want %b", dst_rdy_n, {3'b111, dst_in_n}); end
      end
      if (!rdy_o && !dst_in_n) begin
        exp_d = 8'(8'h10 + k);
        n_checks++; if (dout !== exp_d) begin n_fail++; $display("FAIL bp_data: got %h want %h", dout, exp_d); end
        n_checks++; if (sof_o !== (k != 0) || eof_o !== (k != 7)) begin n_fail++; $display("FAIL bp_flags beat %0d: got sof %b eof %b", k, sof_o, eof_o); end
        k++;
      end
      cycles++;
      cyc();
    end
    idle_src();
    dst_in_n = 1'b0;
    n_checks++; if (k != 8) begin n_fail++; $display("FAIL bp_timeout: got %0d beats want 8", k); end
    @(negedge clk);
    n_checks++; if (fc !== 16'd9 || busy !== 1'b0) begin n_fail++; $display("FAIL bp_count: got %0d/%b want 9/0", fc, busy); end
    $display("back-pressured frame from src 0, %0d beats", k);
    cyc();
  endtask

  task automatic test_sof_error();
    int b1 = 0, b2 = 0, cycles = 0;
    logic [7:0] exp_d;
    while (b2 < 2 && cycles < 40) begin
      idle_src();
      if (b1 < 4) set_beat(1, 8'(8'hB0 + b1), 1'b1, b1 != 3);
      set_beat(2, 8'(8'h30 + b2), b2 != 0, b2 != 1);
      @(negedge clk);
      if (busy && gid == 2'd1) begin
        n_checks++; if (rdy_o !== 1'b1) begin n_fail++; $display("FAIL sof_no_fwd: got src_rdy_out %b want 1", rdy_o); end
        n_checks++; if (fc !== 16'd9) begin n_fail++; $display("FAIL sof_count_hold: got %0d want 9", fc); end
      end
      if (!dst_rdy_n[1] && !rdy_n[1]) b1++;
      if (!rdy_o && !dst_in_n) begin
        exp_d = 8'(8'h30 + b2);
        n_checks++; if (gid !== 2'd2 || b1 != 4) begin n_fail++; $display("FAIL sof_next_grant: got %0d after %0d drops want 2 after 4", gid, b1); end
        n_checks++; if (dout !== exp_d) begin n_fail++; $display("FAIL sof_src2_data: got %h want %h", dout, exp_d); end
        b2++;
      end
      cycles++;
      cyc();
    end
    idle_src();
    n_checks++; if (b1 != 4) begin n_fail++; $display("FAIL sof_consumed: got %0d want 4", b1); end
    @(negedge clk);
    n_checks++; if (serr !== 4'b0010) begin n_fail++; $display("FAIL sof_sticky: got %b want 0010", serr); end
    n_checks++; if (fc !== 16'd10 || busy !== 1'b0) begin n_fail++; $display("FAIL sof_final: got %0d/%b want 10/0", fc, busy); end
    $display("src 1 frame dropped (%0d beats), src 2 frame forwarded", b1);
    cyc();
  endtask

  task automatic test_clear_stats();
    set_beat(3, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_idle: got busy %b want 0", busy); end
    cyc();
    clr = 1'b1;
    @(negedge clk);
    n_checks++; if (gid !== 2'd3 || dout !== 8'h5A) begin n_fail++; $display("FAIL clr_beat: got %0d/%h want 3/5a", gid, dout); end
    n_checks++; if ({sof_o, eof_o, rdy_o} !== 3'b000) begin n_fail++; $display("FAIL clr_flags: got %b want 000", {sof_o, eof_o, rdy_o}); end
    cyc();
    clr = 1'b0;
    idle_src();
    set_beat(0, 8'h01, 1'b0, 1'b0);
    set_beat(2, 8'h02, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++; if (fc !== 16'd0 || serr !== 4'h0) begin n_fail++; $display("FAIL clr_stats: got %0d/%b want 0/0000", fc, serr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clr_state: got busy %b want 0", busy); end
    cyc();
    @(negedge clk);
    n_checks++; if (gid !== 2'd0 || dout !== 8'h01) begin n_fail++; $display("FAIL clr_next_rr: got %0d/%h want 0/01", gid, dout); end
    cyc();
    idle_src();
    @(negedge clk);
    n_checks++; if (fc !== 16'd1) begin n_fail++; $display("FAIL clr_recount: got %0d want 1", fc); end
    $display("single-beat frame from src 3 with clear, then src 0");
    cyc();
  endtask

  task automatic test_reset_midframe();
    set_beat(1, 8'h60, 1'b0, 1'b1);
    cyc();
    cyc();
    set_beat(1, 8'h61, 1'b1, 1'b1);
    cyc();
    set_beat(1, 8'h62, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (gid !== 2'd1 || dout !== 8'h62) begin n_fail++; $display("FAIL rm_beat3: got %0d/%h want 1/62", gid, dout); end
    cyc();
    rst = 1'b0;
    idle_src();
    @(negedge clk);
    n_checks++; if (dst_rdy_n !== 4'hF || rdy_o !== 1'b1) begin n_fail++; $display("FAIL rm_handshake: got %h/%b want f/1", dst_rdy_n, rdy_o); end
    n_checks++; if ({sof_o, eof_o} !== 2'b11 || dout !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %b/%h want 11/00", {sof_o, eof_o}, dout); end
    n_checks++; if (gid !== 2'd0 || busy !== 1'b0 || fc !== 16'd0) begin n_fail++; $display("FAIL rm_state: got %0d/%b/%0d want 0/0/0", gid, busy, fc); end
    cyc();
    set_beat(3, 8'h77, 1'b0, 1'b0);
    cyc();
    @(negedge clk);
    n_checks++; if (gid !== 2'd3 || dst_rdy_n !== 4'b0111) begin n_fail++; $display("FAIL rm_fresh_grant: got %0d/%b want 3/0111", gid, dst_rdy_n); end
    cyc();
    idle_src();
    $display("reset mid-frame, then src 3 granted");
    cyc();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_round_robin();
    test_backpressure();
    test_sof_error();
    test_clear_stats();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
